center_of_mass: RTL and testbench

Computes the centroid of all pixels flagged by the upstream color/motion mask over one camera frame and presents it as an (x, y) coordinate. It sits directly upstream of `predict`, driving the `x_com`/`y_com` inputs that `predict` converts into servo pulse widths for the `pwm` stages. Accumulation runs every pixel clock; the per-frame division uses a multi-cycle restoring divider, so a result appears a fixed number of cycles after each end-of-frame strobe.

---
 rtl/center_of_mass.sv | 152 +++++++++++++++
 tb/tb_center_of_mass.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/center_of_mass.sv
// center_of_mass
//   Accumulates the coordinates of every flagged pixel in a frame. On the
//   end-of-frame strobe it divides the coordinate sums by the pixel count with
//   two parallel restoring dividers and presents the centroid.
// Ports:
//   clk_in       camera clock
//   rst_in       synchronous active-high reset
//   x_in, y_in   current pixel coordinate
//   valid_in     pixel is flagged (accumulate it)
//   tabulate_in  single-cycle end-of-frame strobe
//   x_out, y_out centroid (floor of mean), held between results
//   valid_out    one-cycle pulse when a new centroid is presented
module center_of_mass #(
  parameter int H_WIDTH    = 11,
  parameter int V_WIDTH    = 10,
  parameter int SUM_WIDTH  = 32,
  parameter int MIN_PIXELS = 1
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [H_WIDTH-1:0] x_in,
  input  logic [V_WIDTH-1:0] y_in,
  input  logic               valid_in,
  input  logic               tabulate_in,
  output logic [H_WIDTH-1:0] x_out,
  output logic [V_WIDTH-1:0] y_out,
  output logic               valid_out
);

  localparam int W  = SUM_WIDTH;
  localparam int CW = $clog2(SUM_WIDTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIVIDE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      iter_q, iter_d;
  logic [W-1:0]       sum_x_q, sum_x_d, sum_y_q, sum_y_d, count_q, count_d;
  // Dividend registers shift left one bit per cycle and fill with quotient
  // bits, so after W cycles they hold the quotients.
  logic [W-1:0]       dvd_x_q, dvd_x_d, dvd_y_q, dvd_y_d;
  logic [W-1:0]       rem_x_q, rem_x_d, rem_y_q, rem_y_d;
  logic [W-1:0]       divisor_q, divisor_d;
  logic [H_WIDTH-1:0] x_out_q, x_out_d;
  logic [V_WIDTH-1:0] y_out_q, y_out_d;
  logic               valid_out_q, valid_out_d;

  logic [W-1:0] snap_x, snap_y, snap_cnt;
  logic [W:0]   rem_x_sh, rem_y_sh, diff_x, diff_y;
  logic         ge_x, ge_y;

  always_comb begin
    // The pixel presented alongside the strobe still belongs to this frame.
    snap_x   = sum_x_q + (valid_in ? W'(x_in) : '0);
    snap_y   = sum_y_q + (valid_in ? W'(y_in) : '0);
    snap_cnt = count_q + (valid_in ? W'(1) : '0);
    sum_x_d  = tabulate_in ? '0 : snap_x;
    sum_y_d  = tabulate_in ? '0 : snap_y;
    count_d  = tabulate_in ? '0 : snap_cnt;

    // Restoring step: the partial remainder is below the divisor, so after
    // shifting in one dividend bit it needs W+1 bits.
    rem_x_sh = {rem_x_q, dvd_x_q[W-1]};
    rem_y_sh = {rem_y_q, dvd_y_q[W-1]};
    diff_x   = rem_x_sh - {1'b0, divisor_q};
    diff_y   = rem_y_sh - {1'b0, divisor_q};
    ge_x     = rem_x_sh >= {1'b0, divisor_q};
    ge_y     = rem_y_sh >= {1'b0, divisor_q};

    state_d     = state_q;
    iter_d      = iter_q;
    dvd_x_d     = dvd_x_q;
    dvd_y_d     = dvd_y_q;
    rem_x_d     = rem_x_q;
    rem_y_d     = rem_y_q;
    divisor_d   = divisor_q;
    x_out_d     = x_out_q;
    y_out_d     = y_out_q;
    valid_out_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tabulate_in && (snap_cnt >= W'(MIN_PIXELS))) begin
          dvd_x_d   = snap_x;
          dvd_y_d   = snap_y;
          divisor_d = snap_cnt;
          rem_x_d   = '0;
          rem_y_d   = '0;
          iter_d    = '0;
          state_d   = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        rem_x_d = ge_x ? diff_x[W-1:0] : rem_x_sh[W-1:0];
        rem_y_d = ge_y ? diff_y[W-1:0] : rem_y_sh[W-1:0];
        dvd_x_d = {dvd_x_q[W-2:0], ge_x};
        dvd_y_d = {dvd_y_q[W-2:0], ge_y};
        iter_d  = iter_q + CW'(1);
        if (iter_q == CW'(W-1)) begin
          iter_d  = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Quotient is bounded by the largest coordinate, so truncation is exact.
        x_out_d     = dvd_x_q[H_WIDTH-1:0];
        y_out_d     = dvd_y_q[V_WIDTH-1:0];
        valid_out_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      iter_q      <= '0;
      sum_x_q     <= '0;
      sum_y_q     <= '0;
      count_q     <= '0;
      dvd_x_q     <= '0;
      dvd_y_q     <= '0;
      rem_x_q     <= '0;
      rem_y_q     <= '0;
      divisor_q   <= '0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      valid_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      sum_x_q     <= sum_x_d;
      sum_y_q     <= sum_y_d;
      count_q     <= count_d;
      dvd_x_q     <= dvd_x_d;
      dvd_y_q     <= dvd_y_d;
      rem_x_q     <= rem_x_d;
      rem_y_q     <= rem_y_d;
      divisor_q   <= divisor_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign valid_out = valid_out_q;

endmodule

// File: tb/tb_center_of_mass.sv
module tb_center_of_mass;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] x, x2;
  logic [9:0]  y, y2;
  logic        v, v2, t, t2;
  logic [10:0] x_out, x_out2;
  logic [9:0]  y_out, y_out2;
  logic        valid_out, valid_out2;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  center_of_mass dut (
    .clk_in(clk), .rst_in(rst), .x_in(x), .y_in(y), .valid_in(v),
    .tabulate_in(t), .x_out(x_out), .y_out(y_out), .valid_out(valid_out)
  );

  center_of_mass #(.MIN_PIXELS(4)) dut4 (
    .clk_in(clk), .rst_in(rst), .x_in(x2), .y_in(y2), .valid_in(v2),
    .tabulate_in(t2), .x_out(x_out2), .y_out(y_out2), .valid_out(valid_out2)
  );

  typedef struct packed {
    int n;
    logic [3:0][15:0] px;
    logic [3:0][15:0] py;
    int same;   // strobe coincides with last pixel
    int ex;
    int ey;
  } vec_t;

  vec_t tbl[5];

  function automatic vec_t mk(int n, int x0, int y0, int x1, int y1, int xx2, int yy2,
                              int x3, int y3, int same, int ex, int ey);
    vec_t r;
    r.n = n; r.same = same; r.ex = ex; r.ey = ey;
    r.px[0] = 16'(x0); r.py[0] = 16'(y0);
    r.px[1] = 16'(x1); r.py[1] = 16'(y1);
    r.px[2] = 16'(xx2); r.py[2] = 16'(yy2);
    r.px[3] = 16'(x3); r.py[3] = 16'(y3);
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input int px, input int py);
    // unflagged junk pixel first: must not be accumulated
    x = 11'd1234; y = 10'd999; v = 1'b0; tick();
    x = 11'(px); y = 10'(py); v = 1'b1; tick();
    v = 1'b0;
  endtask

  task automatic tab();
    t = 1'b1; v = 1'b0; tick();
    t = 1'b0;
  endtask

  // Call right after the strobe edge (cycle T+1); n = cycle offset of valid.
  task automatic wait_valid(input int which, output int n);
    n = 0;
    for (int i = 1; i < 100; i++) begin
      if ((which == 0 ? valid_out : valid_out2) == 1'b1) begin
        n = i;
        break;
      end
      tick();
    end
  endtask

  task automatic expect_result(input string name, input int ex, input int ey);
    int n;
    wait_valid(0, n);
    chk({name, "_latency"}, n, 34);
    chk({name, "_x"}, int'(x_out), ex);
    chk({name, "_y"}, int'(y_out), ey);
    tick();
    chk({name, "_pulse1"}, int'(valid_out), 0);
  endtask

  initial begin
    int n, pulses, pn, px_, py_;
    rst = 1'b1; x = '0; y = '0; v = 1'b0; t = 1'b0;
    x2 = '0; y2 = '0; v2 = 1'b0; t2 = 1'b0;

    tbl[0] = mk(1, 100, 50, 0, 0, 0, 0, 0, 0, 0, 100, 50);
    tbl[1] = mk(2, 0, 0, 1279, 719, 0, 0, 0, 0, 1, 639, 359);
    tbl[2] = mk(3, 10, 20, 11, 20, 13, 21, 0, 0, 0, 11, 20);
    tbl[3] = mk(4, 1, 1, 2, 2, 2, 2, 2, 2, 0, 1, 1);
    tbl[4] = mk(2, 1279, 719, 1279, 719, 0, 0, 0, 0, 1, 1279, 719);

    repeat (3) tick();
    rst = 1'b0;
    chk("reset_x", int'(x_out), 0);
    chk("reset_y", int'(y_out), 0);
    chk("reset_valid", int'(valid_out), 0);

    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < tbl[k].n; i++) begin
        if (tbl[k].same != 0 && i == tbl[k].n - 1) begin
          x = 11'(tbl[k].px[i]); y = 10'(tbl[k].py[i]); v = 1'b1; t = 1'b1;
          tick();
          v = 1'b0; t = 1'b0;
        end else begin
          pixel(int'(tbl[k].px[i]), int'(tbl[k].py[i]));
        end
      end
      if (tbl[k].same == 0) tab();
      expect_result($sformatf("vec%0d", k), tbl[k].ex, tbl[k].ey);
    end

    // Full-range sweep: every column, rows alternating between the extremes.
    for (int i = 0; i < 1280; i++) begin
      x = 11'(i); y = (i % 2 == 1) ? 10'd719 : 10'd0; v = 1'b1; tick();
    end
    v = 1'b0;
    tab();
    expect_result("sweep", 639, 359);
    pixel(3, 4); tab();
    expect_result("after_sweep", 3, 4);

    // Empty frame: no result, outputs hold.
    tab();
    pulses = 0;
    repeat (40) begin if (valid_out) pulses++; tick(); end
    chk("empty_pulses", pulses, 0);
    chk("empty_hold_x", int'(x_out), 3);
    chk("empty_hold_y", int'(y_out), 4);

    // MIN_PIXELS=4 instance: 3 pixels rejected, 4 accepted.
    for (int i = 0; i < 3; i++) begin x2 = 11'(20 + i); y2 = 10'd30; v2 = 1'b1; tick(); end
    v2 = 1'b0; t2 = 1'b1; tick(); t2 = 1'b0;
    pulses = 0;
    repeat (40) begin if (valid_out2) pulses++; tick(); end
    chk("min4_pulses", pulses, 0);
    chk("min4_hold_x", int'(x_out2), 0);
    chk("min4_hold_y", int'(y_out2), 0);
    x2 = 11'd4; y2 = 10'd8;  v2 = 1'b1; tick();
    x2 = 11'd4; y2 = 10'd8;  tick();
    x2 = 11'd8; y2 = 10'd8;  tick();
    x2 = 11'd8; y2 = 10'd12; t2 = 1'b1; tick();
    v2 = 1'b0; t2 = 1'b0;
    wait_valid(1, n);
    chk("min4_latency", n, 34);
    chk("min4_x", int'(x_out2), 6);
    chk("min4_y", int'(y_out2), 9);

    // Second strobe during DIVIDE: discarded, but frame boundary honoured.
    pixel(100, 200);
    tab();
    pulses = 0; pn = 0; px_ = 0; py_ = 0;
    for (int i = 1; i <= 80; i++) begin
      if (valid_out) begin pulses++; pn = i; px_ = int'(x_out); py_ = int'(y_out); end
      v = 1'b0; t = 1'b0;
      if (i == 10) begin x = 11'd7; y = 10'd7; v = 1'b1; t = 1'b1; end
      if (i == 11) begin x = 11'd9; y = 10'd9; v = 1'b1; end
      tick();
    end
    v = 1'b0; t = 1'b0;
    chk("dbl_pulses", pulses, 1);
    chk("dbl_latency", pn, 34);
    chk("dbl_x", px_, 100);
    chk("dbl_y", py_, 200);
    tab();
    expect_result("dbl_next", 9, 9);

    // Reset during DIVIDE aborts the division.
    pixel(50, 60);
    tab();
    repeat (14) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_x", int'(x_out), 0);
    chk("rst_y", int'(y_out), 0);
    pulses = 0;
    repeat (40) begin if (valid_out) pulses++; tick(); end
    chk("rst_pulses", pulses, 0);
    pixel(5, 7); tab();
    expect_result("post_rst", 5, 7);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
